// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared types and constants for the PRESENT-80 round controller
package present_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int PRESENT_ROUNDS = 31;
    localparam int PRESENT_KEY_W  = 80;
    localparam int PRESENT_BLK_W  = 64;
    localparam int PRESENT_CNT_W  = 6;

endpackage

// File: rtl/present_round_cnt.sv
// rtl/present_round_cnt.sv - round counter with clear, load-to-1, increment and terminal flag
module present_round_cnt #(
    parameter int CNT_W      = 6,
    parameter int NUM_ROUNDS = 31
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] ONE_VAL = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= ONE_VAL;
        end else if (i_inc) begin
            r_count <= r_count + ONE_VAL;
        end
    end

    assign o_count = r_count;
    // Flags the last sbox/pLayer round; the step after it lands on NUM_ROUNDS+1 for K32.
    assign o_tc    = (r_count == TC_VAL);

endmodule

// File: rtl/present_round_ctrl.sv
// rtl/present_round_ctrl.sv - PRESENT-80 sequencing FSM; optional abort under PRESENT_ABORT_EN
module present_round_ctrl
    import present_pkg::*;
#(
    parameter int NUM_ROUNDS = PRESENT_ROUNDS,
    parameter int CNT_W      = PRESENT_CNT_W
) (
    input  logic             i_clock,
    input  logic             i_reset,
`ifdef PRESENT_ABORT_EN
    input  logic             i_abort,
`endif
    input  logic             i_start,
    input  logic             i_out_ready,
    output logic             o_busy,
    output logic             o_key_load,
    output logic             o_state_load,
    output logic             o_round_en,
    output logic [CNT_W-1:0] o_round_counter,
    output logic             o_final_xor,
    output logic             o_out_valid
);

    state_t r_state;
    logic   r_busy;
    logic   r_key_load;
    logic   r_state_load;
    logic   r_round_en;
    logic   r_final_xor;
    logic   r_out_valid;

    logic   w_abort;
    logic   w_abort_op;
    logic   w_cnt_clr;
    logic   w_cnt_load;
    logic   w_cnt_inc;
    logic   w_cnt_tc;

`ifdef PRESENT_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    // r_busy is high exactly in LOAD, ROUND and FINAL, the only states abort may cancel.
    assign w_abort_op = w_abort && r_busy;

    always_comb begin
        w_cnt_clr  = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_inc  = 1'b0;
        case (r_state)
            IDLE:    w_cnt_load = i_start;
            ROUND:   w_cnt_inc  = 1'b1;
            DONE:    w_cnt_clr  = i_out_ready;
            default: ;
        endcase
        if (w_abort_op) begin
            w_cnt_clr  = 1'b1;
            w_cnt_load = 1'b0;
            w_cnt_inc  = 1'b0;
        end
    end

    present_round_cnt #(
        .CNT_W      (CNT_W),
        .NUM_ROUNDS (NUM_ROUNDS)
    ) u_round_cnt (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clr   (w_cnt_clr),
        .i_load  (w_cnt_load),
        .i_inc   (w_cnt_inc),
        .o_count (o_round_counter),
        .o_tc    (w_cnt_tc)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_key_load   <= 1'b0;
            r_state_load <= 1'b0;
            r_round_en   <= 1'b0;
            r_final_xor  <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_key_load   <= 1'b0;
            r_state_load <= 1'b0;
            r_round_en   <= 1'b0;
            r_final_xor  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state      <= LOAD;
                        r_busy       <= 1'b1;
                        r_key_load   <= 1'b1;
                        r_state_load <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state    <= ROUND;
                    r_round_en <= 1'b1;
                end
                ROUND: begin
                    if (w_cnt_tc) begin
                        r_state     <= FINAL;
                        r_final_xor <= 1'b1;
                    end else begin
                        r_round_en  <= 1'b1;
                    end
                end
                FINAL: begin
                    r_state     <= DONE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    // start in this cycle is dropped; it must still be high once back in IDLE.
                    if (i_out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
            if (w_abort_op) begin
                r_state      <= IDLE;
                r_busy       <= 1'b0;
                r_key_load   <= 1'b0;
                r_state_load <= 1'b0;
                r_round_en   <= 1'b0;
                r_final_xor  <= 1'b0;
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_key_load   = r_key_load;
    assign o_state_load = r_state_load;
    assign o_round_en   = r_round_en;
    assign o_final_xor  = r_final_xor;
    assign o_out_valid  = r_out_valid;

endmodule
